alu_m_pipe: RTL and testbench

- Parametrised successor to the single-cycle integer ALU in the execute stage.
- Adds RV32M/RV64M multiply, divide and remainder with a valid/ready input handshake.
- Base RV-I ops complete in 1 cycle; multiply in 2 cycles; divide/remainder iteratively in XLEN+2 cycles.
- Sits between the decode/operand-mux stage and writeback; writeback consumes the out_valid pulse.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_divider.sv | 54 +++++
 rtl/alu_m_pipe.sv | 191 +++++++++++++++++++
 tb/tb_alu_m_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU with M extension.
// Holds func7/func3 decode constants and the sequencing state type.
package alu_pkg;

  localparam logic [6:0] FUNC7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

endpackage

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Operands are magnitudes; the caller owns all sign handling.
module alu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;

  // r_quo doubles as the dividend shift register: its MSB feeds the partial remainder.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_diff[XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (start) begin
      r_cnt <= CW'(XLEN);
      r_quo <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
    end else if (busy) begin
      r_cnt <= r_cnt - CW'(1);
      r_rem <= w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_fits};
    end
  end

  assign busy      = (r_cnt != '0);
  assign done      = (r_cnt == CW'(1));
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/alu_m_pipe.sv
// Execute-stage integer ALU with RV32M/RV64M multiply/divide.
// Base ops in 1 cycle, multiply in 2, divide/remainder in XLEN+2.
module alu_m_pipe
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] ALUin1,
  input  logic [XLEN-1:0] ALUin2,
  output logic [XLEN-1:0] ALUout,
  output logic            out_valid,
  output logic            out_err
);
  localparam int SHW = $clog2(XLEN);

  state_e            r_state, w_next;
  logic [XLEN-1:0]   r_out;
  logic              r_valid, r_err;
  logic [2*XLEN-1:0] r_prod;
  logic              r_mul_lo, r_neg_q, r_neg_r, r_rem_sel;

  logic              w_accept;
  logic [SHW-1:0]    w_shamt;
  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_base_res;
  logic              w_base_ok;
  logic              w_is_m, w_is_mul, w_is_div;
  logic              w_div_signed, w_div_rem, w_div_zero, w_div_ovf, w_div_fast, w_div_start;
  logic [XLEN-1:0]   w_fast_res, w_abs_a, w_abs_b, w_fix_res, w_mul_res;
  logic              w_sa, w_sb;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
  logic              w_div_busy, w_div_done;
  logic [XLEN-1:0]   w_quo, w_rem;

  assign in_ready  = (r_state == IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_shamt   = ALUin2[SHW-1:0];
  assign w_a_neg   = ALUin1[XLEN-1];
  assign w_b_neg   = ALUin2[XLEN-1];

  always_comb begin
    w_base_ok  = 1'b1;
    w_base_res = '0;
    if (func7 == FUNC7_BASE) begin
      case (func3)
        F3_ADD:  w_base_res = ALUin1 + ALUin2;
        F3_SLL:  w_base_res = ALUin1 << w_shamt;
        F3_SLT:  w_base_res = {{(XLEN-1){1'b0}}, ($signed(ALUin1) < $signed(ALUin2))};
        F3_SLTU: w_base_res = {{(XLEN-1){1'b0}}, (ALUin1 < ALUin2)};
        F3_XOR:  w_base_res = ALUin1 ^ ALUin2;
        F3_SR:   w_base_res = ALUin1 >> w_shamt;
        F3_OR:   w_base_res = ALUin1 | ALUin2;
        F3_AND:  w_base_res = ALUin1 & ALUin2;
        default: w_base_ok  = 1'b0;
      endcase
    end else if (func7 == FUNC7_ALT) begin
      case (func3)
        F3_ADD:  w_base_res = ALUin1 - ALUin2;
        F3_SR:   w_base_res = $signed(ALUin1) >>> w_shamt;
        default: w_base_ok  = 1'b0;
      endcase
    end else begin
      w_base_ok = 1'b0;
    end
  end

  assign w_is_m   = ENABLE_M && (func7 == FUNC7_MULDIV);
  assign w_is_mul = w_is_m && (func3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU});
  assign w_is_div = w_is_m && (func3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU});

  // Sign-extending to 2*XLEN makes one unsigned multiply serve all four variants.
  assign w_sa   = w_a_neg && (func3 == F3_MULH || func3 == F3_MULHSU);
  assign w_sb   = w_b_neg && (func3 == F3_MULH);
  assign w_ma   = {{XLEN{w_sa}}, ALUin1};
  assign w_mb   = {{XLEN{w_sb}}, ALUin2};
  assign w_prod = w_ma * w_mb;
  assign w_mul_res = r_mul_lo ? r_prod[XLEN-1:0] : r_prod[2*XLEN-1:XLEN];

  assign w_div_signed = (func3 == F3_DIV) || (func3 == F3_REM);
  assign w_div_rem    = (func3 == F3_REM) || (func3 == F3_REMU);
  assign w_div_zero   = (ALUin2 == '0);
  assign w_div_ovf    = w_div_signed && (ALUin1 == {1'b1, {(XLEN-1){1'b0}}}) && (ALUin2 == '1);
  assign w_div_fast   = w_div_zero || w_div_ovf;
  assign w_div_start  = w_accept && w_is_div && !w_div_fast;

  always_comb begin
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = w_div_rem ? ALUin1 : '1;
    else if (w_div_ovf)
      w_fast_res = w_div_rem ? '0 : ALUin1;
  end

  assign w_abs_a   = (w_div_signed && w_a_neg) ? -ALUin1 : ALUin1;
  assign w_abs_b   = (w_div_signed && w_b_neg) ? -ALUin2 : ALUin2;
  assign w_fix_res = r_rem_sel ? (r_neg_r ? -w_rem : w_rem)
                               : (r_neg_q ? -w_quo : w_quo);

  alu_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mul) w_next = MUL;
        else if (w_div_start)     w_next = DIV;
      end
      MUL: w_next = IDLE;
      // An idle divider here can only mean a lost start; fall through rather than hang.
      DIV: if (w_div_done || !w_div_busy) w_next = FIX;
      FIX: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_prod    <= '0;
      r_mul_lo  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          if (w_is_mul) begin
            r_prod   <= w_prod;
            r_mul_lo <= (func3 == F3_MUL);
          end else if (w_is_div) begin
            if (w_div_fast) begin
              r_out   <= w_fast_res;
              r_valid <= 1'b1;
            end else begin
              r_neg_q   <= w_div_signed && (w_a_neg ^ w_b_neg);
              r_neg_r   <= w_div_signed && w_a_neg;
              r_rem_sel <= w_div_rem;
            end
          end else if (w_base_ok) begin
            r_out   <= w_base_res;
            r_valid <= 1'b1;
          end else begin
            r_out   <= '1;
            r_valid <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        MUL: begin
          r_out   <= w_mul_res;
          r_valid <= 1'b1;
        end
        FIX: begin
          r_out   <= w_fix_res;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ALUout    = r_out;
  assign out_valid = r_valid;
  assign out_err   = r_err;

endmodule

// File: tb/tb_alu_m_pipe.sv
// Self-checking bench for alu_m_pipe (XLEN=32) against an arithmetic reference model.
module tb_alu_m_pipe;
  logic        clk, rst, in_valid;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] ALUin1, ALUin2;
  logic [31:0] ALUout, nm_out;
  logic        in_ready, out_valid, out_err;
  logic        nm_ready, nm_valid, nm_err;

  int total = 0;
  int bad   = 0;

  alu_m_pipe #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .func3(func3), .func7(func7), .ALUin1(ALUin1), .ALUin2(ALUin2),
    .ALUout(ALUout), .out_valid(out_valid), .out_err(out_err)
  );

  alu_m_pipe #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_ready),
    .func3(func3), .func7(func7), .ALUin1(ALUin1), .ALUin2(ALUin2),
    .ALUout(nm_out), .out_valid(nm_valid), .out_err(nm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {err, result} from the ISA arithmetic rules.
  function automatic logic [32:0] ref_op(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] up;
    logic [31:0] r;
    logic        err;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 32'hFFFF_FFFF;
    err = 1'b0;
    if (f7 == 7'h00) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) begin
      r = a - b;
    end else if (f7 == 7'h20 && f3 == 3'd5) begin
      p = sa >>> b[4:0];
      r = p[31:0];
    end else if (f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = sa * sb; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * longint'(b); r = p[63:32]; end
        3'd3: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
        3'd4: if (b == 0) r = 32'hFFFF_FFFF; else if (ovf) r = a; else begin p = sa / sb; r = p[31:0]; end
        3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: if (b == 0) r = a; else if (ovf) r = 0; else begin p = sa % sb; r = p[31:0]; end
        default: r = (b == 0) ? a : a % b;
      endcase
    end else begin
      err = 1'b1;
    end
    return {err, r};
  endfunction

  function automatic int ref_lat(input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b);
    if (f7 != 7'h01) return 1;
    if (f3 < 3'd4) return 2;
    if (b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Present one op for one cycle, then wait (bounded) for the result pulse.
  task automatic run_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output logic err,
                        output int lat);
    @(negedge clk);
    func7 = f7; func3 = f3; ALUin1 = a; ALUin2 = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = ALUout;
    err = out_err;
  endtask

  task automatic test_reset();
    logic [31:0] res; logic err; int lat, pulses;
    rst = 1'b1; in_valid = 1'b0; func7 = '0; func3 = '0; ALUin1 = '0; ALUin2 = '0;
    repeat (2) @(negedge clk);
    total++; if (ALUout !== 32'd0 || out_valid !== 1'b0 || out_err !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: got out=%h v=%b e=%b want 0/0/0", ALUout, out_valid, out_err);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    run_op(7'h00, 3'd0, 32'd1, 32'd1, res, err, lat);
    total++; if (res !== 32'd2) begin bad++; $display("FAIL pre_add: got %h want 2", res); end
    @(negedge clk);
    func7 = 7'h01; func3 = 3'd4; ALUin1 = 32'd100; ALUin2 = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL div_busy: got ready=%b want 0", in_ready); end
    #2 rst = 1'b1;
    #1;
    total++; if (ALUout !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_div_reset: got out=%h v=%b rdy=%b want 0/0/1", ALUout, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (out_valid) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL aborted_div_pulse: got %0d pulses want 0", pulses); end
    run_op(7'h00, 3'd0, 32'd5, 32'd7, res, err, lat);
    total++; if (res !== 32'd12 || lat !== 1) begin
      bad++; $display("FAIL add_after_reset: got %h lat %0d want 0000000c lat 1", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    func7 = 7'h20; func3 = 3'd0; ALUin1 = 32'd3; ALUin2 = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || ALUout !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL b2b_sub: got %h v=%b want fffffffe v=1", ALUout, out_valid);
    end
    func7 = 7'h20; func3 = 3'd5; ALUin1 = 32'h8000_0000; ALUin2 = 32'h24;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || ALUout !== 32'hF800_0000) begin
      bad++; $display("FAIL b2b_sra: got %h v=%b want f8000000 v=1", ALUout, out_valid);
    end
    func7 = 7'h00; func3 = 3'd3; ALUin1 = 32'd1; ALUin2 = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || ALUout !== 32'd0) begin
      bad++; $display("FAIL b2b_sltu: got %h v=%b want 0 v=1", ALUout, out_valid);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f3s [2] = '{3'd1, 3'd3};
    logic [31:0] exp [2] = '{32'h0000_0000, 32'hFFFF_FFFE};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      func7 = 7'h01; func3 = f3s[i]; ALUin1 = 32'hFFFF_FFFF; ALUin2 = 32'hFFFF_FFFF; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL mul_busy_%0d: got rdy=%b v=%b want 0/0", i, in_ready, out_valid);
      end
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || ALUout !== exp[i] || in_ready !== 1'b1 || out_err !== 1'b0) begin
        bad++; $display("FAIL mul_res_%0d: got %h v=%b rdy=%b want %h v=1 rdy=1", i, ALUout, out_valid, in_ready, exp[i]);
      end
    end
  endtask

  task automatic test_div_hold();
    int lat, rdy_seen;
    @(negedge clk);
    func7 = 7'h01; func3 = 3'd4; ALUin1 = 32'hFFFF_FFF9; ALUin2 = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    func3 = 3'd6;
    lat = 1; rdy_seen = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 34 || ALUout !== 32'hFFFF_FFFD) begin
      bad++; $display("FAIL div_neg7_2: got %h lat %0d want fffffffd lat 34", ALUout, lat);
    end
    total++; if (rdy_seen !== 0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL div_ready: got busy-ready %0d ready-at-pulse %b want 0/1", rdy_seen, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL held_accept: got v=%b rdy=%b want 0/0", out_valid, in_ready);
    end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 34 || ALUout !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL rem_neg7_2: got %h lat %0d want ffffffff lat 34", ALUout, lat);
    end
  endtask

  task automatic test_div_fast();
    logic [2:0]  f3s [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd10, 32'd10, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd10, 32'h8000_0000, 32'd0};
    logic [31:0] res; logic err; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(7'h01, f3s[i], as[i], bs[i], res, err, lat);
      total++; if (res !== exp[i] || err !== 1'b0 || lat !== 1) begin
        bad++; $display("FAIL div_fast_%0d: got %h e=%b lat %0d want %h e=0 lat 1", i, res, err, lat, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] res; logic err; int lat;
    run_op(7'h20, 3'd1, $urandom, $urandom, res, err, lat);
    total++; if (res !== 32'hFFFF_FFFF || err !== 1'b1 || lat !== 1) begin
      bad++; $display("FAIL illegal_alt_sll: got %h e=%b lat %0d want ffffffff e=1 lat 1", res, err, lat);
    end
    @(negedge clk);
    func7 = 7'h01; func3 = 3'd0; ALUin1 = 32'd3; ALUin2 = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (nm_valid !== 1'b1 || nm_out !== 32'hFFFF_FFFF || nm_err !== 1'b1 || nm_ready !== 1'b1) begin
      bad++; $display("FAIL no_m_mul: got %h v=%b e=%b rdy=%b want ffffffff 1/1/1", nm_out, nm_valid, nm_err, nm_ready);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || ALUout !== 32'd12 || out_err !== 1'b0) begin
      bad++; $display("FAIL m_mul: got %h v=%b e=%b want 0000000c 1/0", ALUout, out_valid, out_err);
    end
  endtask

  task automatic test_random();
    logic [6:0]  f7; logic [2:0] f3; logic [31:0] a, b, res; logic err; int lat;
    logic [32:0] expv;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: f7 = 7'h00;
        4:          f7 = 7'h20;
        9:          f7 = 7'($urandom);
        default:    f7 = 7'h01;
      endcase
      f3 = 3'($urandom);
      a  = pick_op();
      b  = pick_op();
      expv = ref_op(f7, f3, a, b);
      run_op(f7, f3, a, b, res, err, lat);
      total++; if (res !== expv[31:0] || err !== expv[32] || lat !== ref_lat(f7, f3, a, b)) begin
        bad++;
        $display("FAIL rand_%0d f7=%h f3=%0d a=%h b=%h: got %h e=%b lat %0d want %h e=%b lat %0d",
                 n, f7, f3, a, b, res, err, lat, expv[31:0], expv[32], ref_lat(f7, f3, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div_hold();
    test_div_fast();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
